// File: rtl/int_fp_donusum.sv
// Signed 32-bit integer to IEEE-754 single converter with iterative normaliser.
// Define ROUND_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module int_fp_donusum #(
    parameter int unsigned EXP_BIAS = 127
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] g1_i,
    input  logic        g_valid_i,
    output logic        g_ready_o,
    output logic [31:0] c_o,
    output logic        c_valid_o,
    input  logic        c_ready_i
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state, state_next;
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  e;
    logic [22:0] mant_trunc;
    logic [22:0] mant_out;
    logic        carry;
    logic [7:0]  exp_biased;

    assign g_ready_o = (state == IDLE) && en_i && !rst_i;

    always_comb begin
        mant_trunc = mag[30:8];
`ifdef ROUND_RNE_EN
        begin : rne
            logic        round_up;
            logic [23:0] mant_sum;
            round_up = mag[7] & ((|mag[6:0]) | mant_trunc[0]);
            mant_sum = {1'b0, mant_trunc} + {23'd0, round_up};
            mant_out = mant_sum[22:0];
            carry    = mant_sum[23];
        end
`else
        mant_out = mant_trunc;
        carry    = 1'b0;
`endif
        // A mantissa carry bumps the exponent; mant_out is already zero then.
        exp_biased = 8'(EXP_BIAS) + {3'b000, e} + {7'd0, carry};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (g_valid_i) state_next = (g1_i == 32'd0) ? DONE : NORM;
                NORM:  if (mag[31]) state_next = ROUND;
                ROUND: state_next = DONE;
                DONE:  if (c_ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sign      <= 1'b0;
            mag       <= '0;
            e         <= '0;
            c_o       <= '0;
            c_valid_o <= 1'b0;
        end else if (!en_i) begin
            sign      <= 1'b0;
            mag       <= '0;
            e         <= '0;
            c_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_valid_i) begin
                        sign <= g1_i[31];
                        // 0x80000000 negates to itself, which is exactly 2^31 unsigned.
                        mag  <= g1_i[31] ? (~g1_i + 32'd1) : g1_i;
                        e    <= 5'd31;
                        if (g1_i == 32'd0) begin
                            c_o       <= '0;
                            c_valid_o <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= mag << 1;
                        e   <= e - 5'd1;
                    end
                end
                ROUND: begin
                    c_o       <= {sign, exp_biased, mant_out};
                    c_valid_o <= 1'b1;
                end
                DONE: begin
                    if (c_ready_i) c_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_fp_donusum.sv
// Self-checking bench for int_fp_donusum; follows ROUND_RNE_EN the same way as the design.
module tb_int_fp_donusum;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [31:0] g1_i;
    logic        g_valid_i;
    logic        g_ready_o;
    logic [31:0] c_o;
    logic        c_valid_o;
    logic        c_ready_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res;

    int_fp_donusum #(.EXP_BIAS(127)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .g1_i     (g1_i),
        .g_valid_i(g_valid_i),
        .g_ready_o(g_ready_o),
        .c_o      (c_o),
        .c_valid_o(c_valid_o),
        .c_ready_i(c_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic int msb_pos(input logic [31:0] x);
        longint m;
        int p;
        m = longint'(signed'(x));
        if (m < 0) m = -m;
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (64'sd1 <<< i)) p = i;
        return p;
    endfunction

    function automatic logic [31:0] ref_float(input logic [31:0] x);
        longint v, m, mant;
        logic s;
        int p, ex;
        if (x == 32'd0) return 32'd0;
        v = longint'(signed'(x));
        s = (v < 0);
        m = s ? -v : v;
        p = msb_pos(x);
        ex = p;
        if (p > 23) begin
            mant = m >>> (p - 23);
`ifdef ROUND_RNE_EN
            begin
                longint rem, half;
                rem  = m - (mant <<< (p - 23));
                half = 64'sd1 <<< (p - 24);
                if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
                if (mant == (64'sd1 <<< 24)) begin
                    mant = 64'sd1 <<< 23;
                    ex   = ex + 1;
                end
            end
`endif
        end else begin
            mant = m <<< (23 - p);
        end
        return {s, 8'(ex + 127), 23'(mant)};
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        if (x == 32'd0) return 0;
        return (31 - msb_pos(x)) + 2;
    endfunction

    task automatic start_op(input logic [31:0] x);
        g1_i      = x;
        g_valid_i = 1'b1;
        @(posedge clk_i); #1;
        g_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!c_valid_o && cyc < 64) begin
            @(posedge clk_i); #1;
            cyc++;
        end
    endtask

    task automatic consume();
        c_ready_i = 1'b1;
        @(posedge clk_i); #1;
        c_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; g1_i = '0; g_valid_i = 1'b0; c_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if (c_o !== 32'd0 || c_valid_o !== 1'b0 || g_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: c_o=%h c_valid=%b g_ready=%b, required 0/0/0", c_o, c_valid_o, g_ready_o);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (g_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: g_ready=%b, required 1", g_ready_o);
        end
        @(posedge clk_i); #1;
        last_res = 32'd0;
    endtask

    task automatic test_directed();
        logic [31:0] vin [6];
        logic [31:0] vexp[6];
        int cyc;
        vin[0] = 32'h00000001; vexp[0] = 32'h3F800000;
        vin[1] = 32'hFFFFFFFE; vexp[1] = 32'hC0000000;
        vin[2] = 32'h00000000; vexp[2] = 32'h00000000;
        vin[3] = 32'h80000000; vexp[3] = 32'hCF000000;
`ifdef ROUND_RNE_EN
        vin[4] = 32'h7FFFFFFF; vexp[4] = 32'h4F000000;
        vin[5] = 32'h01000003; vexp[5] = 32'h4B800002;
`else
        vin[4] = 32'h7FFFFFFF; vexp[4] = 32'h4EFFFFFF;
        vin[5] = 32'h01000003; vexp[5] = 32'h4B800001;
`endif
        for (int i = 0; i < 6; i++) begin
            start_op(vin[i]);
            wait_valid(cyc);
            n_cmp++;
            if (c_o !== vexp[i]) begin
                n_err++;
                $display("FAIL directed_value[%0d] in=%h: got %h, required %h", i, vin[i], c_o, vexp[i]);
            end
            n_cmp++;
            if (cyc != ref_lat(vin[i])) begin
                n_err++;
                $display("FAIL directed_latency[%0d] in=%h: got %0d, required %0d", i, vin[i], cyc, ref_lat(vin[i]));
            end
            last_res = vexp[i];
            consume();
        end
        // Tie with even mantissa: no increment in either build.
        start_op(32'h01000001);
        wait_valid(cyc);
        n_cmp++;
        if (c_o !== 32'h4B800000) begin
            n_err++;
            $display("FAIL tie_even: got %h, required 4b800000", c_o);
        end
        last_res = 32'h4B800000;
        consume();
    endtask

    task automatic test_random();
        logic [31:0] x, exp_v;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            case (i % 3)
                0: x = $urandom;
                1: x = $urandom >> $urandom_range(0, 31);
                default: x = -($urandom >> $urandom_range(0, 31));
            endcase
            exp_v = ref_float(x);
            start_op(x);
            wait_valid(cyc);
            n_cmp++;
            if (c_o !== exp_v || cyc != ref_lat(x)) begin
                n_err++;
                $display("FAIL random[%0d] in=%h: got %h after %0d, required %h after %0d",
                         i, x, c_o, cyc, exp_v, ref_lat(x));
            end
            last_res = exp_v;
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x;
        int cyc;
        x = 32'h00012345;
        start_op(x);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            n_cmp++;
            if (c_o !== ref_float(x) || c_valid_o !== 1'b1 || g_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure[%0d]: c_o=%h valid=%b ready=%b, required %h/1/0",
                         i, c_o, c_valid_o, g_ready_o, ref_float(x));
            end
        end
        last_res = ref_float(x);
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            x = ($urandom >> $urandom_range(0, 31)) | 32'd1;
            start_op(x);
            wait_valid(cyc);
            n_cmp++;
            if (c_o !== ref_float(x)) begin
                n_err++;
                $display("FAIL b2b_value[%0d] in=%h: got %h, required %h", i, x, c_o, ref_float(x));
            end
            last_res = ref_float(x);
            consume();
            n_cmp++;
            if (c_valid_o !== 1'b0 || g_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_return[%0d]: valid=%b ready=%b, required 0/1", i, c_valid_o, g_ready_o);
            end
        end
    endtask

    task automatic test_abort_en();
        int cyc;
        start_op(32'h00000001);
        @(posedge clk_i); #1;
        en_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (c_valid_o !== 1'b0 || g_ready_o !== 1'b0 || c_o !== last_res) begin
            n_err++;
            $display("FAIL abort_norm: valid=%b ready=%b c_o=%h, required 0/0/%h", c_valid_o, g_ready_o, c_o, last_res);
        end
        en_i = 1'b1;
        #1;
        n_cmp++;
        if (g_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_norm_ready: g_ready=%b, required 1", g_ready_o);
        end
        // A result waiting in DONE is dropped when en_i falls.
        start_op(32'hFFFFFF00);
        wait_valid(cyc);
        en_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (c_valid_o !== 1'b0 || c_o !== ref_float(32'hFFFFFF00)) begin
            n_err++;
            $display("FAIL abort_done: valid=%b c_o=%h, required 0/%h", c_valid_o, c_o, ref_float(32'hFFFFFF00));
        end
        en_i = 1'b1;
        @(posedge clk_i); #1;
        start_op(32'h00000300);
        wait_valid(cyc);
        n_cmp++;
        if (c_o !== 32'h44400000 || cyc != ref_lat(32'h00000300)) begin
            n_err++;
            $display("FAIL after_abort: got %h after %0d, required 44400000 after %0d", c_o, cyc, ref_lat(32'h00000300));
        end
        last_res = 32'h44400000;
        consume();
    endtask

    task automatic test_async_reset();
        int cyc;
        start_op(32'h00000001);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (c_o !== 32'd0 || c_valid_o !== 1'b0 || g_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: c_o=%h valid=%b ready=%b, required 0/0/0", c_o, c_valid_o, g_ready_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (g_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_release: g_ready=%b, required 1", g_ready_o);
        end
        @(posedge clk_i); #1;
        start_op(32'hFFFFFFFF);
        wait_valid(cyc);
        n_cmp++;
        if (c_o !== 32'hBF800000) begin
            n_err++;
            $display("FAIL after_reset: got %h, required bf800000", c_o);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_abort_en();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
